// File: rtl/il2_inst_responder.sv
// L2-side responder for the IL1 handshake: serves IL1 line refills as paired-word
// beats and independently drives inclusive back-invalidations of IL1 lines.
module il2_inst_responder #(
    parameter int PC_LENGTH   = 32,
    parameter int BLOCK_BYTES = 32,
    parameter int LINE_ADDR_W = 27
) (
    input  logic                               clk_l2,
    input  logic                               rst_n,
    // IL1 refill
    input  logic                               inst_update_req,
    input  logic [PC_LENGTH-1:0]               pc_up,
    output logic                               update,
    output logic [$clog2(BLOCK_BYTES/8)-1:0]   addr_update,
    output logic [31:0]                        w1_update,
    output logic [31:0]                        w2_update,
    // L2 array read port
    output logic                               l2_rd_req,
    output logic [LINE_ADDR_W-1:0]             l2_rd_addr,
    input  logic                               l2_rd_valid,
    input  logic [BLOCK_BYTES*8-1:0]           l2_rd_line,
    // back-invalidation
    input  logic                               evict_req,
    input  logic [LINE_ADDR_W-1:0]             evict_addr,
    output logic                               evict_ready,
    output logic                               evict_done,
    output logic                               inst_replace_req,
    output logic [LINE_ADDR_W-1:0]             inst_addr_replace,
    input  logic                               inst_replace_il1_ack,
    output logic                               L2_inst_il1_ack
);

    localparam int BEATS    = BLOCK_BYTES / 8;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int LINE_W   = BLOCK_BYTES * 8;
    localparam int HALF_W   = BLOCK_BYTES * 4;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_RD,
        RF_STREAM,
        RF_DRAIN
    } refill_state_t;

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_REQ,
        EV_WACK,
        EV_CLOSE
    } evict_state_t;

    refill_state_t     rf_state, rf_next;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] line_q;

    evict_state_t      ev_state, ev_next;
    logic              done_d;

    // ------------------------------------------------------------------
    // Refill path
    // ------------------------------------------------------------------
    always_ff @(posedge clk_l2) begin
        if (!rst_n) begin
            rf_state   <= RF_IDLE;
            beat_q     <= '0;
            l2_rd_addr <= '0;
        end else begin
            rf_state <= rf_next;
            beat_q   <= beat_d;
            if (rf_state == RF_IDLE && inst_update_req)
                l2_rd_addr <= pc_up[PC_LENGTH-1:OFFSET_W];
        end
    end

    // Line buffer needs no reset: it is only read while streaming.
    always_ff @(posedge clk_l2) begin
        if (rf_state == RF_RD && l2_rd_valid)
            line_q <= l2_rd_line;
    end

    always_comb begin
        rf_next     = rf_state;
        beat_d      = beat_q;
        update      = 1'b0;
        addr_update = '0;
        w1_update   = '0;
        w2_update   = '0;
        l2_rd_req   = 1'b0;
        case (rf_state)
            RF_IDLE: begin
                if (inst_update_req)
                    rf_next = RF_RD;
            end
            RF_RD: begin
                l2_rd_req = 1'b1;
                beat_d    = '0;
                if (l2_rd_valid)
                    rf_next = RF_STREAM;
            end
            RF_STREAM: begin
                update      = 1'b1;
                addr_update = beat_q;
                w1_update   = line_q[32*int'(beat_q) +: 32];
                w2_update   = line_q[HALF_W + 32*int'(beat_q) +: 32];
                if (beat_q == BEAT_W'(BEATS-1)) begin
                    beat_d  = '0;
                    rf_next = RF_DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            RF_DRAIN: begin
                // IL1 still holds the request it just got served; wait for it to drop.
                if (!inst_update_req)
                    rf_next = RF_IDLE;
            end
            default: rf_next = RF_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Back-invalidation path
    // ------------------------------------------------------------------
    always_ff @(posedge clk_l2) begin
        if (!rst_n) begin
            ev_state          <= EV_IDLE;
            evict_done        <= 1'b0;
            inst_addr_replace <= '0;
        end else begin
            ev_state   <= ev_next;
            evict_done <= done_d;
            if (ev_state == EV_IDLE && evict_req)
                inst_addr_replace <= evict_addr;
        end
    end

    always_comb begin
        ev_next          = ev_state;
        done_d           = 1'b0;
        evict_ready      = 1'b0;
        inst_replace_req = 1'b0;
        L2_inst_il1_ack  = 1'b0;
        case (ev_state)
            EV_IDLE: begin
                evict_ready = 1'b1;
                if (evict_req)
                    ev_next = EV_REQ;
            end
            EV_REQ: begin
                inst_replace_req = 1'b1;
                ev_next          = EV_WACK;
            end
            EV_WACK: begin
                if (inst_replace_il1_ack)
                    ev_next = EV_CLOSE;
            end
            EV_CLOSE: begin
                L2_inst_il1_ack = 1'b1;
                if (!inst_replace_il1_ack) begin
                    ev_next = EV_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ev_next = EV_IDLE;
        endcase
    end

endmodule

// File: tb/tb_il2_inst_responder.sv
// Directed self-checking bench for il2_inst_responder: refill beats, stale request
// drain, back-invalidation handshake, concurrency and mid-operation reset.
module tb_il2_inst_responder;

    logic         clk_l2 = 1'b0;
    logic         rst_n;
    logic         inst_update_req;
    logic [31:0]  pc_up;
    logic         update;
    logic [1:0]   addr_update;
    logic [31:0]  w1_update;
    logic [31:0]  w2_update;
    logic         l2_rd_req;
    logic [26:0]  l2_rd_addr;
    logic         l2_rd_valid;
    logic [255:0] l2_rd_line;
    logic         evict_req;
    logic [26:0]  evict_addr;
    logic         evict_ready;
    logic         evict_done;
    logic         inst_replace_req;
    logic [26:0]  inst_addr_replace;
    logic         inst_replace_il1_ack;
    logic         L2_inst_il1_ack;

    int n_checks = 0;
    int n_errors = 0;

    il2_inst_responder #(
        .PC_LENGTH  (32),
        .BLOCK_BYTES(32),
        .LINE_ADDR_W(27)
    ) dut (
        .clk_l2              (clk_l2),
        .rst_n               (rst_n),
        .inst_update_req     (inst_update_req),
        .pc_up               (pc_up),
        .update              (update),
        .addr_update         (addr_update),
        .w1_update           (w1_update),
        .w2_update           (w2_update),
        .l2_rd_req           (l2_rd_req),
        .l2_rd_addr          (l2_rd_addr),
        .l2_rd_valid         (l2_rd_valid),
        .l2_rd_line          (l2_rd_line),
        .evict_req           (evict_req),
        .evict_addr          (evict_addr),
        .evict_ready         (evict_ready),
        .evict_done          (evict_done),
        .inst_replace_req    (inst_replace_req),
        .inst_addr_replace   (inst_addr_replace),
        .inst_replace_il1_ack(inst_replace_il1_ack),
        .L2_inst_il1_ack     (L2_inst_il1_ack)
    );

    always #5 clk_l2 = ~clk_l2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 ns later, away from the edge.
    task automatic step();
        @(posedge clk_l2);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic check_beat(input string tag, input int i, input logic [31:0] base);
        check({tag, "_update"}, 64'(update), 64'd1);
        check({tag, "_addr"}, 64'(addr_update), 64'(i));
        check({tag, "_w1"}, 64'(w1_update), 64'(base + 32'(i)));
        check({tag, "_w2"}, 64'(w2_update), 64'(base + 32'(i + 4)));
    endtask

    initial begin
        rst_n = 1'b0;
        inst_update_req = 1'b0;
        pc_up = '0;
        l2_rd_valid = 1'b0;
        l2_rd_line = '0;
        evict_req = 1'b0;
        evict_addr = '0;
        inst_replace_il1_ack = 1'b0;

        // Reset state
        step(); step();
        rst_n = 1'b1;
        check("rst_update", 64'(update), 64'd0);
        check("rst_rd_req", 64'(l2_rd_req), 64'd0);
        check("rst_rd_addr", 64'(l2_rd_addr), 64'd0);
        check("rst_w1", 64'(w1_update), 64'd0);
        check("rst_evict_ready", 64'(evict_ready), 64'd1);
        check("rst_l2ack", 64'(L2_inst_il1_ack), 64'd0);
        check("rst_addr_repl", 64'(inst_addr_replace), 64'd0);
        check("rst_evict_done", 64'(evict_done), 64'd0);

        // Read return outside RD is ignored
        l2_rd_valid = 1'b1;
        l2_rd_line = make_line(32'hDEAD_0000);
        step();
        l2_rd_valid = 1'b0;
        check("idle_valid_update", 64'(update), 64'd0);
        check("idle_valid_rd_req", 64'(l2_rd_req), 64'd0);

        // Basic refill, L2 returns 3 cycles after request
        pc_up = 32'h0000_1044;
        inst_update_req = 1'b1;
        step();
        check("t1_rd_req", 64'(l2_rd_req), 64'd1);
        check("t1_rd_addr", 64'(l2_rd_addr), 64'h82);
        step(); step();
        check("t1_rd_req_held", 64'(l2_rd_req), 64'd1);
        check("t1_no_update", 64'(update), 64'd0);
        l2_rd_valid = 1'b1;
        l2_rd_line = make_line(32'hA000_0000);
        step();
        l2_rd_valid = 1'b0;
        check("t1_rd_req_drop", 64'(l2_rd_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_beat("t1_beat", i, 32'hA000_0000);
            if (i == 0) inst_update_req = 1'b0;
            step();
        end
        check("t1_drain_update", 64'(update), 64'd0);
        step();
        check("t1_idle_rd_req", 64'(l2_rd_req), 64'd0);

        // Stale request held after stream: no re-serve until dropped
        pc_up = 32'h0000_2000;
        inst_update_req = 1'b1;
        step();
        check("t2_rd_addr", 64'(l2_rd_addr), 64'h100);
        l2_rd_valid = 1'b1;
        l2_rd_line = make_line(32'hB000_0000);
        step();
        l2_rd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat("t2_beat", i, 32'hB000_0000);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("t2_stale_rd_req", 64'(l2_rd_req), 64'd0);
            check("t2_stale_update", 64'(update), 64'd0);
            step();
        end
        check("t2_still_drain", 64'(l2_rd_req), 64'd0);
        inst_update_req = 1'b0;
        step();
        check("t2_idle_rd_req", 64'(l2_rd_req), 64'd0);
        inst_update_req = 1'b1;
        step();
        check("t2_reassert_rd_req", 64'(l2_rd_req), 64'd1);
        l2_rd_valid = 1'b1;
        step();
        l2_rd_valid = 1'b0;
        inst_update_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        step();

        // Back-invalidation
        evict_addr = 27'h12345;
        evict_req = 1'b1;
        step();
        evict_req = 1'b0;
        check("t3_replace_req", 64'(inst_replace_req), 64'd1);
        check("t3_addr_repl", 64'(inst_addr_replace), 64'h12345);
        check("t3_ready_busy", 64'(evict_ready), 64'd0);
        step();
        check("t3_replace_pulse_end", 64'(inst_replace_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t3_wack_l2ack", 64'(L2_inst_il1_ack), 64'd0);
            step();
        end
        inst_replace_il1_ack = 1'b1;
        step();
        check("t3_l2ack_set", 64'(L2_inst_il1_ack), 64'd1);
        step();
        check("t3_l2ack_hold", 64'(L2_inst_il1_ack), 64'd1);
        check("t3_no_done_yet", 64'(evict_done), 64'd0);
        inst_replace_il1_ack = 1'b0;
        step();
        check("t3_l2ack_clr", 64'(L2_inst_il1_ack), 64'd0);
        check("t3_done", 64'(evict_done), 64'd1);
        check("t3_ready", 64'(evict_ready), 64'd1);
        step();
        check("t3_done_pulse", 64'(evict_done), 64'd0);

        // Concurrent refill and evict
        pc_up = 32'h0000_0040;
        inst_update_req = 1'b1;
        step();
        check("t4_rd_addr", 64'(l2_rd_addr), 64'h2);
        l2_rd_valid = 1'b1;
        l2_rd_line = make_line(32'hC000_0000);
        step();
        l2_rd_valid = 1'b0;
        check_beat("t4_beat", 0, 32'hC000_0000);
        step();
        evict_addr = 27'h0ABC;
        evict_req = 1'b1;
        check_beat("t4_beat", 1, 32'hC000_0000);
        step();
        evict_req = 1'b0;
        inst_update_req = 1'b0;
        check_beat("t4_beat", 2, 32'hC000_0000);
        check("t4_replace_req", 64'(inst_replace_req), 64'd1);
        check("t4_addr_repl", 64'(inst_addr_replace), 64'h0ABC);
        step();
        check_beat("t4_beat", 3, 32'hC000_0000);
        evict_addr = 27'h0777;
        evict_req = 1'b1;
        step();
        evict_req = 1'b0;
        check("t4_drain_update", 64'(update), 64'd0);
        check("t4_ignored_req", 64'(inst_replace_req), 64'd0);
        check("t4_addr_kept", 64'(inst_addr_replace), 64'h0ABC);
        step();
        check("t4_ignored_req2", 64'(inst_replace_req), 64'd0);
        inst_replace_il1_ack = 1'b1;
        step();
        check("t4_l2ack", 64'(L2_inst_il1_ack), 64'd1);
        inst_replace_il1_ack = 1'b0;
        step();
        check("t4_done", 64'(evict_done), 64'd1);
        check("t4_ready", 64'(evict_ready), 64'd1);
        step();

        // Reset during STREAM beat 2
        pc_up = 32'h0000_1044;
        inst_update_req = 1'b1;
        step();
        l2_rd_valid = 1'b1;
        l2_rd_line = make_line(32'hA000_0000);
        step();
        l2_rd_valid = 1'b0;
        step(); step();
        check("t5_beat2_addr", 64'(addr_update), 64'd2);
        rst_n = 1'b0;
        step();
        check("t5_rst_update", 64'(update), 64'd0);
        check("t5_rst_addr", 64'(addr_update), 64'd0);
        check("t5_rst_w1", 64'(w1_update), 64'd0);
        check("t5_rst_w2", 64'(w2_update), 64'd0);
        check("t5_rst_rd_addr", 64'(l2_rd_addr), 64'd0);
        rst_n = 1'b1;
        inst_update_req = 1'b0;
        step();
        check("t5_no_resume", 64'(update), 64'd0);
        check("t5_no_rd_req", 64'(l2_rd_req), 64'd0);

        // Reset during CLOSE
        evict_addr = 27'h0055;
        evict_req = 1'b1;
        step();
        evict_req = 1'b0;
        step();
        inst_replace_il1_ack = 1'b1;
        step();
        check("t5_close_l2ack", 64'(L2_inst_il1_ack), 64'd1);
        rst_n = 1'b0;
        step();
        check("t5_rst_l2ack", 64'(L2_inst_il1_ack), 64'd0);
        check("t5_rst_ready", 64'(evict_ready), 64'd1);
        check("t5_rst_done", 64'(evict_done), 64'd0);
        check("t5_rst_addr_repl", 64'(inst_addr_replace), 64'd0);
        check("t5_rst_replace_req", 64'(inst_replace_req), 64'd0);
        rst_n = 1'b1;
        inst_replace_il1_ack = 1'b0;
        step();
        check("t5_no_done_after", 64'(evict_done), 64'd0);
        check("t5_ready_after", 64'(evict_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/il2_inst_responder.md
Name: il2_inst_responder

Overview:
- L2-side counterpart of the L1 instruction cache handshake.
- Serves IL1 refill requests by fetching the requested line from the L2 array read port. It then streams the line to IL1 as paired-word beats on the update bus.
- Independently initiates inclusive back-invalidations: inst_replace_req to IL1, waits for IL1's ack, then closes the four-phase handshake with L2_inst_il1_ack.
- Sits between IL1 and the L2 data/tag array.

Parameters:
- PC_LENGTH, 32, width of IL1 request address pc_up
- BLOCK_BYTES, 32, cache line size in bytes; BEATS = BLOCK_BYTES/8 (4), each beat carries one word of each half-line
- LINE_ADDR_W, 27, width of line address (PC_LENGTH - log2(BLOCK_BYTES)); also width of inst_addr_replace

Ports:
- clk_l2  in  1  clock
- rst_n  in  1  synchronous active-low reset
- inst_update_req  in  1  IL1 refill request, level, held until IL1 sees update
- pc_up  in  PC_LENGTH  miss address from IL1, stable while inst_update_req=1
- update  out  1  beat valid to IL1
- addr_update  out  log2(BEATS)  beat slot index
- w1_update  out  32  word from lower half-line, slot addr_update
- w2_update  out  32  word from upper half-line, slot addr_update
- l2_rd_req  out  1  L2 array line read request
- l2_rd_addr  out  LINE_ADDR_W  line address = pc_up[PC_LENGTH-1:log2(BLOCK_BYTES)]
- l2_rd_valid  in  1  line data valid, one-cycle pulse
- l2_rd_line  in  BLOCK_BYTES*8  line data; lower half = bits [BLOCK_BYTES*4-1:0]
- evict_req  in  1  L2 requests back-invalidation of a line, one-cycle pulse
- evict_addr  in  LINE_ADDR_W  line to invalidate
- evict_ready  out  1  evict FSM idle, evict_req accepted
- evict_done  out  1  one-cycle pulse, back-invalidation complete
- inst_replace_req  out  1  one-cycle pulse to IL1
- inst_addr_replace  out  LINE_ADDR_W  held from accept until done
- inst_replace_il1_ack  in  1  IL1 ack, level
- L2_inst_il1_ack  out  1  closing ack to IL1, level

Behaviour:
- Reset (rst_n low at clk_l2 edge), regardless of state:
  - Both FSMs go to IDLE.
  - update=0, addr_update=0, w1/w2=0, l2_rd_req=0, l2_rd_addr=0.
  - inst_replace_req=0, inst_addr_replace=0, L2_inst_il1_ack=0, evict_done=0, evict_ready=1.
  - Line buffer contents are don't-care.
  - Reset mid-stream or mid-handshake aborts without completing.
- Refill FSM: IDLE -> RD -> STREAM -> DRAIN -> IDLE.
  - IDLE: on inst_update_req=1, capture line address of pc_up into l2_rd_addr; next state RD.
  - RD: l2_rd_req=1 held. On l2_rd_valid=1, latch l2_rd_line into line buffer, drop l2_rd_req; next state STREAM.
  - STREAM: update=1 for exactly BEATS consecutive cycles with addr_update = 0,1,..,BEATS-1.
    - w1_update = buffer lower-half word[addr_update]; w2_update = upper-half word[addr_update].
    - First beat is the cycle after l2_rd_valid; minimum request-to-first-beat latency = 2 cycles plus L2 read latency.
    - Stream is not stalled by inst_update_req dropping mid-stream; all beats are always sent.
  - DRAIN: update=0; wait until inst_update_req=0 (IL1 drops it one cycle after the first update), then IDLE. This prevents re-serving a stale request.
    - If inst_update_req is already 0 on entry, go to IDLE the next cycle.
    - A new request is accepted only from IDLE.
- Evict FSM: IDLE -> REQ -> WACK -> CLOSE -> IDLE, independent of the refill FSM.
  - IDLE: evict_ready=1. On evict_req, latch evict_addr into inst_addr_replace; next state REQ. evict_req while not IDLE is ignored (initiator must check evict_ready).
  - REQ: inst_replace_req=1 for one cycle; next state WACK.
  - WACK: wait inst_replace_il1_ack=1, then CLOSE with L2_inst_il1_ack=1.
  - CLOSE: hold L2_inst_il1_ack=1 until inst_replace_il1_ack=0. Then L2_inst_il1_ack=0, evict_done=1 for one cycle, IDLE.
  - If inst_replace_il1_ack is already 1 when entering WACK, it is accepted in that cycle.
- Simultaneous refill and evict are legal and proceed concurrently. Address conflicts are resolved by the L2 controller, not this block.
- l2_rd_valid outside RD is ignored.

Test Plan:
- Basic refill: pc_up=0x0000_1044, req=1; L2 returns line with word i = 0xA000_0000+i after 3 cycles.
  - Expect l2_rd_addr=0x82.
  - 4 update beats: (addr, w1, w2) = (0,A0,A4), (1,A1,A5), (2,A2,A6), (3,A3,A7).
  - Then DRAIN until req low.
- Stale request: IL1 keeps inst_update_req=1 for 3 extra cycles after stream.
  - Expect no second l2_rd_req until req seen low and re-asserted.
- Back-invalidation: evict_req with evict_addr=0x12345.
  - Expect inst_replace_req pulse 1 cycle later with addr 0x12345.
  - IL1 acks after 5 cycles -> L2_inst_il1_ack=1 next cycle.
  - IL1 drops ack -> L2_inst_il1_ack=0, evict_done pulse, evict_ready=1.
- Concurrent: evict_req issued during STREAM beat 1.
  - Expect beats unaffected and replace handshake completing normally.
  - Second evict_req during WACK is ignored (no extra inst_replace_req).
- Reset mid-operation: rst_n low during STREAM beat 2 and during CLOSE.
  - Expect all outputs at reset values next edge, evict_ready=1, no evict_done pulse.
